// File: rtl/serial_arb_pkg.sv
// ============================================================================
// Module      : serial_arb_pkg
// Description : Shared types and constants for the serial transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arb_pkg;

    localparam int GRANT_W = 3;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_COPY = 3'd2,
        GAP       = 3'd3,
        CLOSE     = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module      : rr_priority_pick
// Description : Round-robin winner search starting one above last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
    import serial_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 4
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [GRANT_W-1:0]     last_grant,
    output logic [GRANT_W-1:0]     winner,
    output logic                   any_req
);

    logic               w_hi_found;
    logic [GRANT_W-1:0] w_hi_idx;
    logic [GRANT_W-1:0] w_lo_idx;

    // Lowest request above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = GRANT_W'(i);
                if (GRANT_W'(i) > last_grant) begin
                    w_hi_idx   = GRANT_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign winner  = w_hi_found ? w_hi_idx : w_lo_idx;
    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
// ============================================================================
// Module      : serial_tx_arbiter
// Description : Round-robin sharing of one quick_rs232 transmitter between
//               NUM_SOURCES byte producers, owning the tx handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_SOURCES         = 4,
    parameter int COPY_TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES          = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SOURCES-1:0]        req_valid,
    input  logic [BYTE_W*NUM_SOURCES-1:0] req_data,
    output logic [NUM_SOURCES-1:0]        req_ack,
    output logic                          tx_transaction,
    output logic [BYTE_W-1:0]             tx_data,
    output logic                          tx_data_ready,
    input  logic                          tx_data_copied,
    input  logic                          tx_busy,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int c_CNT_MAX = (COPY_TIMEOUT_CYCLES > GAP_CYCLES) ? COPY_TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_COPY_LAST = c_CNT_W'(COPY_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [GRANT_W-1:0] c_LAST_INIT = GRANT_W'(NUM_SOURCES - 1);

    arb_state_t             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [GRANT_W-1:0]     r_last_grant;
    logic [GRANT_W-1:0]     r_grant;
    logic [BYTE_W-1:0]      r_byte;
    logic [BYTE_W-1:0]      r_tx_data;
    logic                   r_tx_ready;
    logic                   r_tx_trans;
    logic [NUM_SOURCES-1:0] r_ack;
    logic                   r_timeout;

    arb_state_t             w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [GRANT_W-1:0]     w_last_grant_nxt;
    logic [GRANT_W-1:0]     w_grant_nxt;
    logic [BYTE_W-1:0]      w_byte_nxt;
    logic [BYTE_W-1:0]      w_tx_data_nxt;
    logic                   w_tx_ready_nxt;
    logic                   w_tx_trans_nxt;
    logic [NUM_SOURCES-1:0] w_ack_nxt;
    logic                   w_timeout_nxt;

    logic [GRANT_W-1:0]     w_winner;
    logic                   w_any_req;
    logic [BYTE_W-1:0]      w_sel_byte;
    logic [NUM_SOURCES-1:0] w_grant_onehot;

    rr_priority_pick #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_pick (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    always_comb begin
        w_sel_byte     = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (w_winner == GRANT_W'(i)) begin
                w_sel_byte = req_data[BYTE_W*i +: BYTE_W];
            end
            if (r_grant == GRANT_W'(i)) begin
                w_grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_byte_nxt       = r_byte;
        w_tx_data_nxt    = r_tx_data;
        w_tx_ready_nxt   = r_tx_ready;
        w_tx_trans_nxt   = r_tx_trans;
        w_ack_nxt        = '0;
        w_timeout_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_byte_nxt       = w_sel_byte;
                    w_grant_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_tx_trans_nxt   = 1'b1;
                    w_state_nxt      = LOAD;
                end
            end
            LOAD: begin
                w_tx_data_nxt  = r_byte;
                w_tx_ready_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = WAIT_COPY;
            end
            WAIT_COPY: begin
                if (tx_data_copied) begin
                    w_tx_ready_nxt = 1'b0;
                    w_ack_nxt      = w_grant_onehot;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = GAP;
                end else if (r_cnt == c_COPY_LAST) begin
                    // Abandon the grant; the source keeps requesting and the
                    // pointer has already moved past it.
                    w_tx_ready_nxt = 1'b0;
                    w_timeout_nxt  = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = GAP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CLOSE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            CLOSE: begin
                if (!tx_busy) begin
                    w_tx_trans_nxt = 1'b0;
                    w_tx_data_nxt  = '0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_cnt_nxt      = '0;
                w_tx_ready_nxt = 1'b0;
                w_tx_trans_nxt = 1'b0;
                w_tx_data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= c_LAST_INIT;
            r_grant      <= '0;
            r_byte       <= '0;
            r_tx_data    <= '0;
            r_tx_ready   <= 1'b0;
            r_tx_trans   <= 1'b0;
            r_ack        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_byte       <= w_byte_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_ready   <= w_tx_ready_nxt;
            r_tx_trans   <= w_tx_trans_nxt;
            r_ack        <= w_ack_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign req_ack        = r_ack;
    assign tx_transaction = r_tx_trans;
    assign tx_data        = r_tx_data;
    assign tx_data_ready  = r_tx_ready;
    assign grant_id       = r_grant;
    assign busy           = (r_state != IDLE);
    assign timeout_err    = r_timeout;

endmodule

`default_nettype wire
